// File: rtl/swap48_rr_arbiter_if.sv
// Request/response bundle for the shared 48-bit bit-reversal arbiter.
// master is the arbiter side; slave is the requester/consumer side.
interface swap48_rr_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned CNT_W   = 16
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*48-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  out_valid;
  logic [47:0]           out_data;
  logic [ID_W-1:0]       out_id;
  logic                  out_ready;
  logic                  busy;
  logic [CNT_W-1:0]      xfer_count;

  modport master (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_id, busy, xfer_count
  );

  modport slave (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_id, busy, xfer_count
  );
endinterface

// File: rtl/swap48_rr_arbiter.sv
// Round-robin arbiter feeding a single registered slot with the bit-reversed
// word of the winning requester.
module swap48_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned CNT_W   = 16
) (
  input logic                 clk,
  input logic                 rst,
  swap48_rr_arbiter_if.master bus
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e             stateQ, stateD;
  logic [ID_W-1:0]    rrPtrQ, rrPtrD;
  logic [ID_W-1:0]    outIdQ, outIdD;
  logic [47:0]        outDataQ, outDataD;
  logic [CNT_W-1:0]   xferCountQ, xferCountD;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grantId, grantNext;
  logic [47:0]        grantWord, revWord;
  logic               grantValid, canAccept, accept, drain;

  // First valid requester at or after rrPtrQ, wrapping modulo NUM_REQ.
  always_comb begin
    int unsigned     idx;
    logic [ID_W-1:0] idxW;
    grant      = '0;
    grantValid = 1'b0;
    grantId    = '0;
    grantNext  = '0;
    grantWord  = '0;
    idx        = 0;
    idxW       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(rrPtrQ) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idxW = idx[ID_W-1:0];
      if (!grantValid && bus.req_valid[idxW]) begin
        grantValid  = 1'b1;
        grant[idxW] = 1'b1;
        grantId     = idxW;
        grantNext   = (idx + 1 == NUM_REQ) ? '0 : idxW + 1'b1;
        grantWord   = bus.req_data[48*idx +: 48];
      end
    end
  end

  always_comb begin
    revWord = '0;
    for (int b = 0; b < 48; b++) revWord[b] = grantWord[47-b];
  end

  assign canAccept = (stateQ == StEmpty) || bus.out_ready;
  assign accept    = grantValid && canAccept;
  assign drain     = (stateQ == StFull) && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ     <= StEmpty;
      rrPtrQ     <= '0;
      outIdQ     <= '0;
      outDataQ   <= '0;
      xferCountQ <= '0;
    end else begin
      stateQ     <= stateD;
      rrPtrQ     <= rrPtrD;
      outIdQ     <= outIdD;
      outDataQ   <= outDataD;
      xferCountQ <= xferCountD;
    end
  end

  // A simultaneous drain and accept reloads the slot and stays Full.
  always_comb begin
    stateD     = stateQ;
    rrPtrD     = rrPtrQ;
    outIdD     = outIdQ;
    outDataD   = outDataQ;
    xferCountD = xferCountQ;
    if (accept) begin
      stateD   = StFull;
      rrPtrD   = grantNext;
      outIdD   = grantId;
      outDataD = revWord;
    end else if (drain) begin
      stateD = StEmpty;
    end
    if (drain && (xferCountQ != '1)) xferCountD = xferCountQ + 1'b1;
  end

  always_comb begin
    bus.req_ready  = grant & {NUM_REQ{canAccept}};
    bus.out_valid  = (stateQ == StFull);
    bus.out_data   = outDataQ;
    bus.out_id     = outIdQ;
    bus.xfer_count = xferCountQ;
    bus.busy       = (stateQ == StFull) || (|bus.req_valid);
  end

endmodule

// File: tb/tb_swap48_rr_arbiter.sv
// Directed bench for swap48_rr_arbiter (4 requesters, 4-bit counter so that
// saturation is reachable).
module tb_swap48_rr_arbiter;
  localparam int unsigned NumReq = 4;
  localparam int unsigned IdW    = 2;
  localparam int unsigned CntW   = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  swap48_rr_arbiter_if #(.NUM_REQ(NumReq), .ID_W(IdW), .CNT_W(CntW)) bus ();

  swap48_rr_arbiter #(.NUM_REQ(NumReq), .ID_W(IdW), .CNT_W(CntW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setData(input int k, input logic [47:0] w);
    bus.req_data[48*k +: 48] = w;
  endtask

  logic [47:0] revTbl [4];
  int          expCnt;

  initial begin
    checks   = 0;
    failures = 0;
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_id", bus.out_id, 0);
    chk("rst_xfer_count", bus.xfer_count, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_req_ready", bus.req_ready, 0);

    // 1: single requester 0
    setData(0, 48'h0000_0000_0001);
    bus.req_valid = 4'b0001;
    bus.out_ready = 1'b1;
    #1;
    chk("t1_req_ready", bus.req_ready, 4'b0001);
    chk("t1_busy", bus.busy, 1);
    tick();
    bus.req_valid = 4'b0000;
    chk("t1_out_valid", bus.out_valid, 1);
    chk("t1_out_data", bus.out_data, 48'h8000_0000_0000);
    chk("t1_out_id", bus.out_id, 0);
    chk("t1_cnt_before", bus.xfer_count, 0);
    tick();
    chk("t1_empty", bus.out_valid, 0);
    chk("t1_cnt_after", bus.xfer_count, 1);

    // 2: requester 2, then back-to-back reload from requester 2 (ptr is 1)
    setData(2, 48'h0000_0000_00FF);
    bus.req_valid = 4'b0100;
    #1;
    chk("t2_req_ready", bus.req_ready, 4'b0100);
    tick();
    chk("t2a_out_data", bus.out_data, 48'hFF00_0000_0000);
    chk("t2a_out_id", bus.out_id, 2);
    setData(2, 48'hA5A5_A5A5_A5A5);
    #1;
    chk("t2_reload_ready", bus.req_ready, 4'b0100);
    tick();
    bus.req_valid = 4'b0000;
    chk("t2b_out_valid", bus.out_valid, 1);
    chk("t2b_out_data", bus.out_data, 48'hA5A5_A5A5_A5A5);
    chk("t2b_out_id", bus.out_id, 2);
    chk("t2b_cnt", bus.xfer_count, 2);
    tick();
    chk("t2_empty", bus.out_valid, 0);
    chk("t2_cnt", bus.xfer_count, 3);

    // 3: all requesters valid, full throughput after reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    setData(0, 48'h0000_0000_0001);
    setData(1, 48'h0000_0000_0002);
    setData(2, 48'h0000_0000_0004);
    setData(3, 48'h0000_0000_0008);
    revTbl[0] = 48'h8000_0000_0000;
    revTbl[1] = 48'h4000_0000_0000;
    revTbl[2] = 48'h2000_0000_0000;
    revTbl[3] = 48'h1000_0000_0000;
    bus.req_valid = 4'b1111;
    bus.out_ready = 1'b1;
    #1;
    chk("t3_first_ready", bus.req_ready, 4'b0001);
    for (int n = 1; n <= 8; n++) begin
      tick();
      chk($sformatf("t3_valid_%0d", n), bus.out_valid, 1);
      chk($sformatf("t3_id_%0d", n), bus.out_id, (n - 1) % 4);
      chk($sformatf("t3_data_%0d", n), bus.out_data, revTbl[(n - 1) % 4]);
    end
    chk("t3_cnt7", bus.xfer_count, 7);
    bus.req_valid = 4'b0000;
    tick();
    chk("t3_cnt8", bus.xfer_count, 8);
    chk("t3_empty", bus.out_valid, 0);

    // 4: backpressure with requesters 1 and 3 pending (ptr is 0)
    bus.req_valid = 4'b0001;
    bus.out_ready = 1'b0;
    tick();
    bus.req_valid = 4'b1010;
    for (int n = 0; n < 3; n++) begin
      #1;
      chk($sformatf("t4_ready_%0d", n), bus.req_ready, 4'b0000);
      chk($sformatf("t4_data_%0d", n), bus.out_data, 48'h8000_0000_0000);
      chk($sformatf("t4_id_%0d", n), bus.out_id, 0);
      chk($sformatf("t4_valid_%0d", n), bus.out_valid, 1);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("t4_grant1", bus.req_ready, 4'b0010);
    tick();
    chk("t4_id1", bus.out_id, 1);
    chk("t4_data1", bus.out_data, 48'h4000_0000_0000);
    chk("t4_cnt9", bus.xfer_count, 9);
    bus.req_valid = 4'b1000;
    #1;
    chk("t4_grant3", bus.req_ready, 4'b1000);
    tick();
    chk("t4_id3", bus.out_id, 3);
    chk("t4_data3", bus.out_data, 48'h1000_0000_0000);
    bus.req_valid = 4'b0000;
    tick();
    chk("t4_cnt11", bus.xfer_count, 11);
    chk("t4_empty", bus.out_valid, 0);

    // 5: reset while Full and stalled (ptr is 3 after granting 2)
    bus.req_valid = 4'b0100;
    tick();
    bus.req_valid = 4'b0000;
    bus.out_ready = 1'b0;
    chk("t5_full", bus.out_valid, 1);
    chk("t5_full_id", bus.out_id, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_out_valid", bus.out_valid, 0);
    chk("t5_cnt", bus.xfer_count, 0);
    chk("t5_out_data", bus.out_data, 0);
    bus.req_valid = 4'b1111;
    bus.out_ready = 1'b1;
    #1;
    chk("t5_grant0", bus.req_ready, 4'b0001);
    tick();
    chk("t5_id0", bus.out_id, 0);
    bus.req_valid = 4'b0000;
    tick();
    chk("t5_cnt1", bus.xfer_count, 1);

    // 6: counter saturation with a 4-bit counter
    bus.req_valid = 4'b0001;
    for (int n = 1; n <= 20; n++) begin
      tick();
      expCnt = (n > 15) ? 15 : n;
      chk($sformatf("t6_cnt_%0d", n), bus.xfer_count, expCnt);
    end
    bus.req_valid = 4'b0000;
    tick();
    chk("t6_cnt_sat", bus.xfer_count, 15);
    chk("t6_empty", bus.out_valid, 0);
    tick();
    chk("t6_cnt_hold", bus.xfer_count, 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
